// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the top_sequencer block
// State encoding, phase codes, OSD field layout and phase-order helper.
package seq_pkg;

   localparam int DEPTH      = 64;
   localparam int IDX_W      = 6;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ALU,
      ST_STORE,
      ST_DONE
   } state_e;

   localparam logic [1:0] PH_IDLE  = 2'd0;
   localparam logic [1:0] PH_LOAD  = 2'd1;
   localparam logic [1:0] PH_ALU   = 2'd2;
   localparam logic [1:0] PH_STORE = 2'd3;

   localparam int OSD_W        = 22;
   localparam int OSD_OP_LSB   = 18;
   localparam int OSD_SRCA_LSB = 12;
   localparam int OSD_SRCB_LSB = 6;
   localparam int OSD_DST_LSB  = 0;

   localparam logic [1:0] SEL_IMM = 2'd1;

   // First enabled phase strictly after cur, in LOAD, ALU, STORE order.
   function automatic state_e next_phase(input state_e cur, input logic [2:0] pe);
      logic [2:0] mask;
      state_e     nxt;
      case (cur)
         ST_IDLE: mask = 3'b111;
         ST_LOAD: mask = 3'b110;
         ST_ALU:  mask = 3'b100;
         default: mask = 3'b000;
      endcase
      mask = mask & pe;
      if (mask[0])      nxt = ST_LOAD;
      else if (mask[1]) nxt = ST_ALU;
      else if (mask[2]) nxt = ST_STORE;
      else              nxt = ST_DONE;
      return nxt;
   endfunction

endpackage

// File: rtl/seq_index_counter.sv
// rtl/seq_index_counter.sv - element index with A/B sub-step toggle
// One extra index bit so a full-depth count never wraps before the last-element compare.
module seq_index_counter #(
   parameter int IDX_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             advance_i,
   input  logic [IDX_W:0]   count_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             sub_b_o,
   output logic             last_o
);

   localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);

   logic [IDX_W:0] idx_q, idx_d;
   logic           sub_q, sub_d;

   always_comb begin
      idx_d = idx_q;
      sub_d = sub_q;
      if (clear_i) begin
         idx_d = '0;
         sub_d = 1'b0;
      end else if (advance_i) begin
         if (sub_q) begin
            idx_d = idx_q + ONE;
            sub_d = 1'b0;
         end else begin
            sub_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         idx_q <= '0;
         sub_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         sub_q <= sub_d;
      end
   end

   assign idx_o   = idx_q[IDX_W-1:0];
   assign sub_b_o = sub_q;
   assign last_o  = sub_q && (idx_q == count_i - ONE);

endmodule

// File: rtl/top_sequencer.sv
// rtl/top_sequencer.sv - LOAD/ALU/STORE control sequencer driving the top datapath
// A sampled start is held one cycle in IDLE, so element 0 appears one edge after sampling.
module top_sequencer
   import seq_pkg::*;
#(
   parameter int DEPTH      = seq_pkg::DEPTH,
   parameter int IDX_W      = seq_pkg::IDX_W,
   parameter int DATA_WIDTH = seq_pkg::DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  start,
   input  logic                  abort,
   input  logic [2:0]            phase_en,
   input  logic [IDX_W:0]        count,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic [3:0]            opcode,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            phase,
   output logic                  X,
   output logic                  Y,
   output logic                  R_W,
   output logic [IDX_W-1:0]      W_INST,
   output logic [IDX_W-1:0]      R_INST,
   output logic [DATA_WIDTH-1:0] ADDR,
   output logic [OSD_W-1:0]      OSD,
   output logic [1:0]            sel,
   output logic [DATA_WIDTH-1:0] B_imm,
   output logic                  res_strobe,
   output logic [IDX_W-1:0]      res_idx
);

   localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

   state_e         state_q, state_d;
   logic           start_q, start_d;
   logic [2:0]     pe_q;
   logic [IDX_W:0] cnt_q;
   logic           ctr_clear, ctr_adv, last;
   logic [IDX_W-1:0] idx;
   logic           sub_b;

   seq_index_counter #(.IDX_W(IDX_W)) u_index (
      .clk_i     (CLK),
      .rst_ni    (RST_N),
      .clear_i   (ctr_clear),
      .advance_i (ctr_adv),
      .count_i   (cnt_q),
      .idx_o     (idx),
      .sub_b_o   (sub_b),
      .last_o    (last)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         pe_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         if (start_d) begin
            pe_q  <= phase_en;
            cnt_q <= (count > DEPTH_C) ? DEPTH_C : count;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      start_d   = 1'b0;
      ctr_clear = 1'b0;
      ctr_adv   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            ctr_clear = 1'b1;
            if (abort)
               state_d = ST_IDLE;
            else if (start_q)
               state_d = (cnt_q == '0) ? ST_DONE : next_phase(ST_IDLE, pe_q);
            else
               start_d = start;
         end
         ST_LOAD, ST_ALU, ST_STORE: begin
            if (abort) begin
               state_d   = ST_IDLE;
               ctr_clear = 1'b1;
            end else begin
               ctr_adv = 1'b1;
               if (last) begin
                  state_d   = next_phase(state_q, pe_q);
                  ctr_clear = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d   = ST_IDLE;
            ctr_clear = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      phase      = PH_IDLE;
      X          = 1'b0;
      Y          = 1'b0;
      R_W        = 1'b0;
      W_INST     = '0;
      R_INST     = '0;
      ADDR       = '0;
      OSD        = '0;
      sel        = '0;
      B_imm      = '0;
      res_strobe = 1'b0;
      res_idx    = '0;
      unique case (state_q)
         ST_LOAD: begin
            busy   = 1'b1;
            phase  = PH_LOAD;
            X      = 1'b1;
            R_W    = 1'b1;
            ADDR   = DATA_WIDTH'(idx);
            W_INST = idx;
         end
         ST_ALU: begin
            busy  = 1'b1;
            phase = PH_ALU;
            sel   = SEL_IMM;
            B_imm = imm;
            OSD[OSD_OP_LSB +: 4]       = opcode;
            OSD[OSD_SRCA_LSB +: IDX_W] = idx;
            // Destination only in sub-step B, where the Result is valid.
            if (sub_b) begin
               OSD[OSD_DST_LSB +: IDX_W] = idx;
               res_strobe = 1'b1;
               res_idx    = idx;
            end
         end
         ST_STORE: begin
            busy   = 1'b1;
            phase  = PH_STORE;
            Y      = 1'b1;
            R_INST = idx;
            ADDR   = DATA_WIDTH'(idx);
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_top_sequencer.sv
// tb/tb_top_sequencer.sv - directed self-checking bench for top_sequencer
module tb_top_sequencer;

   logic        CLK = 1'b0;
   logic        RST_N, start, abort;
   logic [2:0]  phase_en;
   logic [6:0]  count;
   logic [31:0] imm;
   logic [3:0]  opcode;
   logic        busy, done, X, Y, R_W, res_strobe;
   logic [1:0]  phase, sel;
   logic [5:0]  W_INST, R_INST, res_idx;
   logic [31:0] ADDR, B_imm;
   logic [21:0] OSD;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   top_sequencer dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort),
      .phase_en(phase_en), .count(count), .imm(imm), .opcode(opcode),
      .busy(busy), .done(done), .phase(phase), .X(X), .Y(Y), .R_W(R_W),
      .W_INST(W_INST), .R_INST(R_INST), .ADDR(ADDR), .OSD(OSD), .sel(sel),
      .B_imm(B_imm), .res_strobe(res_strobe), .res_idx(res_idx)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 64'(busy), 0);
      check({tag, "_done"}, 64'(done), 0);
      check({tag, "_phase"}, 64'(phase), 0);
      check({tag, "_xyrw"}, 64'({X, Y, R_W}), 0);
      check({tag, "_inst"}, 64'({W_INST, R_INST}), 0);
      check({tag, "_addr"}, 64'(ADDR), 0);
      check({tag, "_osd"}, 64'(OSD), 0);
      check({tag, "_sel_bimm"}, 64'({sel, B_imm}), 0);
      check({tag, "_res"}, 64'({res_strobe, res_idx}), 0);
   endtask

   // Expected outputs for phase ph (1 LOAD, 2 ALU, 3 STORE), element e, sub-step s (0 A, 1 B).
   task automatic expect_cycle(input int ph, input int e, input int s);
      logic [21:0] eo;
      logic [5:0]  ei;
      ei = e[5:0];
      eo = '0;
      if (ph == 2) begin
         eo[21:18] = opcode;
         eo[17:12] = ei;
         if (s == 1) eo[5:0] = ei;
      end
      check("busy", 64'(busy), 1);
      check("done", 64'(done), 0);
      check("phase", 64'(phase), 64'(ph));
      check("X", 64'(X), 64'(ph == 1));
      check("Y", 64'(Y), 64'(ph == 3));
      check("R_W", 64'(R_W), 64'(ph == 1));
      check("ADDR", 64'(ADDR), (ph == 1 || ph == 3) ? 64'(e) : 0);
      check("W_INST", 64'(W_INST), (ph == 1) ? 64'(e) : 0);
      check("R_INST", 64'(R_INST), (ph == 3) ? 64'(e) : 0);
      check("sel", 64'(sel), (ph == 2) ? 1 : 0);
      check("B_imm", 64'(B_imm), (ph == 2) ? 64'(imm) : 0);
      check("OSD", 64'(OSD), 64'(eo));
      check("res_strobe", 64'(res_strobe), 64'(ph == 2 && s == 1));
      check("res_idx", 64'(res_idx), (ph == 2 && s == 1) ? 64'(e) : 0);
   endtask

   // Full sequence; n is the hand-clamped element count; poke is the cycle to pulse start (-1 none).
   task automatic run_seq(input logic [2:0] pe, input logic [6:0] cnt, input int n, input int poke);
      int c;
      phase_en = pe;
      count    = cnt;
      start    = 1'b1;
      tick();
      start = 1'b0;
      check("pending_busy", 64'(busy), 0);
      tick();
      c = 0;
      for (int ph = 1; ph <= 3; ph++) begin
         if (pe[ph-1]) begin
            for (int e = 0; e < n; e++) begin
               for (int s = 0; s < 2; s++) begin
                  expect_cycle(ph, e, s);
                  start = (c == poke);
                  c++;
                  tick();
               end
            end
         end
      end
      start = 1'b0;
      check("end_done", 64'(done), 1);
      check("end_busy", 64'(busy), 0);
      check("end_phase", 64'(phase), 0);
      tick();
      check_idle("after_done");
      tick();
      check_idle("after_done2");
   endtask

   task automatic degenerate(input logic [2:0] pe, input logic [6:0] cnt);
      phase_en = pe;
      count    = cnt;
      start    = 1'b1;
      tick();
      start = 1'b0;
      check("deg_busy0", 64'(busy), 0);
      check("deg_done0", 64'(done), 0);
      tick();
      check("deg_done1", 64'(done), 1);
      check("deg_busy1", 64'(busy), 0);
      tick();
      check_idle("deg_after");
   endtask

   initial begin
      RST_N = 1'b0; start = 1'b0; abort = 1'b0;
      phase_en = '0; count = '0; imm = '0; opcode = '0;
      tick();
      tick();
      check_idle("reset");
      RST_N = 1'b1;
      tick();
      check_idle("post_reset");

      run_seq(3'b001, 7'd64, 64, -1);

      imm = 32'd43;
      opcode = 4'd0;
      run_seq(3'b010, 7'd64, 64, -1);

      imm = 32'h1234_5678;
      opcode = 4'hA;
      run_seq(3'b111, 7'd4, 4, -1);

      degenerate(3'b111, 7'd0);
      degenerate(3'b000, 7'd5);

      run_seq(3'b001, 7'd100, 64, -1);

      // Reset while LOAD is at element 10.
      phase_en = 3'b001;
      count = 7'd20;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      repeat (20) tick();
      check("load_e10_addr", 64'(ADDR), 10);
      check("load_e10_winst", 64'(W_INST), 10);
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      check_idle("mid_reset");
      tick();
      check_idle("mid_reset2");
      run_seq(3'b001, 7'd3, 3, -1);

      // Abort on ALU element 5 sub-step B with start also high.
      imm = 32'd7;
      opcode = 4'h3;
      phase_en = 3'b010;
      count = 7'd8;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      repeat (11) tick();
      check("alu_e5_strobe", 64'(res_strobe), 1);
      check("alu_e5_idx", 64'(res_idx), 5);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check_idle("abort");
      tick();
      check_idle("abort2");
      tick();
      check_idle("abort3");

      // Start pulsed mid-STORE must be ignored.
      run_seq(3'b100, 7'd6, 6, 5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
